// File: rtl/tft_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tft_text_pkg
//  Brief    : Shared constants, FSM encoding and cell-address helper for the
//             480x272 TFT text-mode character buffer (60x17 cells of 8x16).
//  Revision : 1.0  initial release
// ============================================================================
package tft_text_pkg;

  localparam int COLS  = 60;
  localparam int ROWS  = 17;
  localparam int CELLS = 1020;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  // Sized copies of the geometry limits for direct comparison with counters.
  localparam logic [9:0] LAST_CELL = 10'(CELLS - 1);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // row*60 + col as (row<<6) - (row<<2) + col. Evaluated modulo 1024; every
  // legal cell lands below 1020, so the truncated result is exact.
  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [9:0] row_w;
    row_w = {5'd0, row};
    return (row_w << 6) - (row_w << 2) + {3'd0, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tft_text_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tft_text_wr_fifo
//  Brief    : Small synchronous FIFO with push/pop, flush, empty and count.
//             DEPTH must be a power of two (>= 2) so the pointers wrap freely.
//  Revision : 1.0  initial release
// ============================================================================
module tft_text_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       tft_clock_9m,
  input  logic                       system_reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Overflowing pushes and underflowing pops are ignored rather than corrupting state.
  assign w_push_ok = push && (r_count != c_full);
  assign w_pop_ok  = pop && (r_count != '0);

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

  // Pointer and occupancy bookkeeping; flush discards everything including a same-cycle push.
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge tft_clock_9m) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/tft_text_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tft_text_arbiter
//  Brief    : Owns the single-port character RAM. Display reads have fixed
//             priority; UART characters are queued and written at the cursor;
//             a full-screen blanking pass runs after reset and on request.
//  Revision : 1.0  initial release
// ============================================================================
module tft_text_arbiter
  import tft_text_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BLANK_CHAR = tft_text_pkg::BLANK_CHAR
) (
  input  logic       tft_clock_9m,
  input  logic       system_reset_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [7:0] char_code,
  output logic       char_valid
);

  localparam int c_fifo_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_fifo_aw:0] c_fifo_full = (c_fifo_aw + 1)'(FIFO_DEPTH);

  state_t           r_state;
  state_t           w_state_n;
  logic [9:0]       r_clr_addr;
  logic [9:0]       w_clr_addr_n;
  logic [4:0]       r_cur_row;
  logic [4:0]       w_cur_row_n;
  logic [5:0]       r_cur_col;
  logic [5:0]       w_cur_col_n;
  logic             r_rst_done;
  logic             r_slot_d;
  logic [7:0]       r_char_hold;

  logic             w_disp_slot;
  logic [9:0]       w_slot_addr;
  logic [9:0]       w_cur_addr;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_fifo_empty;
  logic [7:0]       w_fifo_head;
  logic [c_fifo_aw:0] w_fifo_count;

  assign w_disp_slot = (pix_x != 10'h3ff) && (pix_y != 10'h3ff) && (pix_x[2:0] == 3'd0);
  assign w_slot_addr = cell_addr(pix_y[8:4], pix_x[9:3]);
  assign w_cur_addr  = cell_addr(r_cur_row, {1'b0, r_cur_col});

  assign clr_busy = (r_state == ST_CLEAR);
  assign wr_ready = (w_fifo_count < c_fifo_full) && (r_state != ST_CLEAR);
  assign w_push   = wr_valid && wr_ready;

  // RAM data arrives the cycle after the slot; pass it straight through then, else hold.
  assign char_valid = r_slot_d;
  assign char_code  = r_slot_d ? ram_rdata : r_char_hold;

  tft_text_wr_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .tft_clock_9m   (tft_clock_9m),
    .system_reset_n (system_reset_n),
    .flush          (w_flush),
    .push           (w_push),
    .push_data      (wr_char),
    .pop            (w_pop),
    .head           (w_fifo_head),
    .empty          (w_fifo_empty),
    .count          (w_fifo_count)
  );

  // State, clear address and cursor registers.
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_cur_row  <= '0;
      r_cur_col  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_clr_addr <= w_clr_addr_n;
      r_cur_row  <= w_cur_row_n;
      r_cur_col  <= w_cur_col_n;
    end
  end

  // First cycle out of reset is held quiet so RAM outputs match their reset values; slot tracking.
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_rst_done  <= 1'b0;
      r_slot_d    <= 1'b0;
      r_char_hold <= '0;
    end else begin
      r_rst_done <= 1'b1;
      r_slot_d   <= w_disp_slot && r_rst_done;
      if (r_slot_d) r_char_hold <= ram_rdata;
    end
  end

  // Next-state, cursor and RAM port arbitration; the display slot overrides everything.
  always_comb begin
    w_state_n    = r_state;
    w_clr_addr_n = r_clr_addr;
    w_cur_row_n  = r_cur_row;
    w_cur_col_n  = r_cur_col;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;

    case (r_state)
      ST_CLEAR: begin
        if (clr_req) begin
          w_clr_addr_n = '0;
          w_flush      = 1'b1;
        end else if (r_rst_done && !w_disp_slot) begin
          ram_we    = 1'b1;
          ram_addr  = r_clr_addr;
          ram_wdata = BLANK_CHAR;
          if (r_clr_addr == LAST_CELL) begin
            w_state_n    = ST_IDLE;
            w_clr_addr_n = '0;
            w_cur_row_n  = '0;
            w_cur_col_n  = '0;
          end else begin
            w_clr_addr_n = r_clr_addr + 10'd1;
          end
        end
      end

      ST_IDLE: begin
        if (clr_req) begin
          // A character accepted this same cycle is dropped by the flush.
          w_state_n    = ST_CLEAR;
          w_clr_addr_n = '0;
          w_flush      = 1'b1;
        end else if (!w_fifo_empty) begin
          if (w_fifo_head == CHAR_CR) begin
            w_pop       = 1'b1;
            w_cur_col_n = '0;
          end else if (w_fifo_head == CHAR_LF) begin
            w_pop       = 1'b1;
            w_cur_col_n = '0;
            w_cur_row_n = (r_cur_row == LAST_ROW) ? 5'd0 : r_cur_row + 5'd1;
          end else if (!w_disp_slot) begin
            w_pop     = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = w_cur_addr;
            ram_wdata = w_fifo_head;
            if (r_cur_col == LAST_COL) begin
              w_cur_col_n = '0;
              w_cur_row_n = (r_cur_row == LAST_ROW) ? 5'd0 : r_cur_row + 5'd1;
            end else begin
              w_cur_col_n = r_cur_col + 6'd1;
            end
          end
        end
      end

      default: begin
        w_state_n = ST_CLEAR;
      end
    endcase

    if (w_disp_slot) begin
      ram_we    = 1'b0;
      ram_addr  = w_slot_addr;
      ram_wdata = '0;
    end

    if (!r_rst_done) begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/tft_text_arbiter.md
Name: tft_text_arbiter

Overview:
- Owns the single-port character buffer RAM (60x17 cells of 8x16 glyphs on the 480x272 panel).
- Arbitrates RAM access between two requesters:
  - the display read path, which has fixed priority and is driven by pix_x/pix_y from the TFT timing generator;
  - a UART character write stream, buffered in a small FIFO.
- Sequences a full-screen clear after reset and on request.
- Outputs the character code for the current cell to the glyph ROM/pixel stage.

Parameters:
- COLS, 60, character columns per row (480/8).
- ROWS, 17, character rows (272/16).
- FIFO_DEPTH, 4, write FIFO entries (power of two).
- BLANK_CHAR, 8'h20, code written by clear.

Ports:
- tft_clock_9m  in  1  pixel clock; all logic in this domain.
- system_reset_n  in  1  reset, asynchronous, active-low.
- pix_x  in  10  pixel column request from timing generator; 10'h3ff = no request.
- pix_y  in  10  pixel row request; 10'h3ff = no request.
- wr_valid  in  1  UART character valid.
- wr_char  in  8  UART character.
- wr_ready  out  1  FIFO accepts wr_char when wr_valid && wr_ready.
- clr_req  in  1  single-cycle pulse: start screen clear.
- clr_busy  out  1  clear in progress.
- ram_addr  out  10  character RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid 1 cycle after address.
- char_code  out  8  character code for the current cell.
- char_valid  out  1  char_code updated this cycle.

Behaviour:
- Display slot:
  - disp_slot = pix_x!=3ff && pix_y!=3ff && pix_x[2:0]==0.
  - Slot address = (pix_y>>4)*COLS + (pix_x>>3); the maximum is 1019.
  - In a slot, ram_we=0 and ram_addr=slot address, unconditionally; this overrides any write or clear.
  - Cycle after a slot: char_code<=ram_rdata, char_valid=1 for one cycle. char_code holds otherwise.
- Write FIFO:
  - Depth FIFO_DEPTH, with registered read/write pointers and count.
  - wr_ready = (count<FIFO_DEPTH) && state!=CLEAR.
  - Push and pop in the same cycle leave count unchanged.
- Cursor:
  - Held as cur_row (5b) and cur_col (6b); write address = cur_row*COLS+cur_col.
- FSM states: CLEAR, IDLE.
  - Reset -> CLEAR, clr_addr=0.
  - CLEAR:
    - Every non-slot cycle: ram_we=1, ram_addr=clr_addr, ram_wdata=BLANK_CHAR, clr_addr++.
    - After writing address COLS*ROWS-1: go to IDLE, cursor=(0,0), clr_addr=0.
    - The FIFO is flushed on entry to CLEAR. clr_busy=1 in CLEAR.
  - IDLE, FIFO non-empty, head=8'h0D (CR): pop, cur_col=0, no RAM access. Allowed in slot cycles.
  - IDLE, head=8'h0A (LF): pop, cur_col=0, cur_row=(cur_row==ROWS-1)?0:cur_row+1. Allowed in slot cycles.
  - IDLE, other head, non-slot cycle: ram_we=1, ram_addr=cursor address, ram_wdata=head, pop, then advance the cursor:
    - col+1;
    - at col COLS-1: col=0 and row+1;
    - at (ROWS-1,COLS-1): wrap to (0,0).
  - IDLE, printable head in a slot cycle: stall; head is retained.
  - clr_req in IDLE -> CLEAR next cycle.
  - clr_req while already in CLEAR restarts clr_addr at 0.
  - clr_req in the same cycle as a wr_valid handshake: the clear wins, and the accepted character is discarded by the flush.
- Reset values:
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - char_code=0, char_valid=0.
  - clr_busy=1, wr_ready=0.
  - FIFO empty, cursor (0,0).
- Async reset mid-clear or mid-write returns to CLEAR at address 0; the screen is re-blanked.
- Arithmetic:
  - Multiply by COLS is a constant multiply: shift-add (x<<6)-(x<<2).
  - Address width is 10b with no overflow by construction.

Decomposition:
- Shared package tft_text_pkg holds:
  - constants COLS, ROWS, CELLS=1020, BLANK_CHAR, CHAR_CR=8'h0D, CHAR_LF=8'h0A;
  - FSM state encoding;
  - the cell-address function row*COLS+col.
- One sub-module, tft_text_wr_fifo: a parameterised synchronous FIFO with push/pop, full/empty and count.

Test Plan:
- Reset release, pix_x=pix_y=3ff -> 1020 consecutive ram_we cycles, addresses 0..1019 with wdata 20h; then clr_busy=0, wr_ready=1.
- After the clear, push "A"(41h), "B"(42h) -> writes 41h@0, 42h@1. Then pix_x=16, pix_y=32 -> ram_addr=122, and char_valid the next cycle with char_code=ram_rdata.
- Push 41h while pix_x cycles 0..7 on row 0 -> no write when pix_x[2:0]==0; write on the first non-slot cycle; no slot read is ever dropped.
- Cursor (3,59) + "X" -> write @239, cursor (4,0). Cursor (16,59) + "Y" -> write @1019, cursor (0,0). CR then LF from (5,7) -> cursor (6,0) with no RAM writes.
- 5 pushes with no pops possible (continuous slots disabled via clr) -> wr_ready=0 after 4 entries; the 5th is held off until a pop.
- clr_req with 3 chars queued -> FIFO empty next cycle, clr_busy=1, full 1020-cell clear, cursor (0,0).
